// File: rtl/dcache_controller.sv
// rtl/dcache_controller.sv - direct-mapped write-back write-allocate data cache with miss sequencer
module dcache_controller #(
    parameter int INDEX_BITS = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        read,
    input  logic        write,
    input  logic [7:0]  address,
    input  logic [7:0]  writedata,
    output logic [7:0]  readdata,
    output logic        busywait,
    output logic        mem_read,
    output logic        mem_write,
    output logic [5:0]  mem_address,
    output logic [31:0] mem_writedata,
    input  logic [31:0] mem_readdata,
    input  logic        mem_busywait
);

    localparam int SETS     = 1 << INDEX_BITS;
    localparam int TAG_BITS = 6 - INDEX_BITS;

    typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH, FILL} state_t;

    state_t state_q, state_d;

    logic [SETS-1:0]     valid_q;
    logic [SETS-1:0]     dirty_q;
    logic [TAG_BITS-1:0] tag_q  [SETS];
    logic [31:0]         data_q [SETS];

    logic [INDEX_BITS-1:0] index;
    logic [TAG_BITS-1:0]   req_tag;
    logic [1:0]            offset;
    logic [31:0]           line;
    logic                  request;
    logic                  hit;

    assign index   = address[2 +: INDEX_BITS];
    assign req_tag = address[7 -: TAG_BITS];
    assign offset  = address[1:0];
    assign line    = data_q[index];
    assign request = read ^ write;
    assign hit     = valid_q[index] && (tag_q[index] == req_tag);

    assign readdata = line[{offset, 3'b000} +: 8];
    assign busywait = !reset && request && !((state_q == IDLE) && hit);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_address   = '0;
        mem_writedata = '0;
        case (state_q)
            IDLE: begin
                if (request && !hit) begin
                    state_d = dirty_q[index] ? WRITEBACK : FETCH;
                end
            end
            WRITEBACK: begin
                mem_write     = 1'b1;
                mem_address   = {tag_q[index], index};
                mem_writedata = line;
                if (!mem_busywait) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                mem_read    = 1'b1;
                mem_address = {req_tag, index};
                if (!mem_busywait) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Block data lands on the FETCH exit edge; tag/valid follow one edge later in FILL.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            dirty_q <= '0;
            for (int i = 0; i < SETS; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            if ((state_q == IDLE) && write && !read && hit) begin
                data_q[index][{offset, 3'b000} +: 8] <= writedata;
                dirty_q[index]                       <= 1'b1;
            end
            if ((state_q == FETCH) && !mem_busywait) begin
                data_q[index] <= mem_readdata;
            end
            if (state_q == FILL) begin
                tag_q[index]   <= req_tag;
                valid_q[index] <= 1'b1;
                dirty_q[index] <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dcache_controller.sv
// tb/tb_dcache_controller.sv - directed self-checking bench for dcache_controller
module tb_dcache_controller;

    logic        clock;
    logic        reset;
    logic        read;
    logic        write;
    logic [7:0]  address;
    logic [7:0]  writedata;
    logic [7:0]  readdata;
    logic        busywait;
    logic        mem_read;
    logic        mem_write;
    logic [5:0]  mem_address;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        mem_busywait;

    int checks;
    int failures;
    int cyc;

    dcache_controller #(.INDEX_BITS(3)) dut (
        .clock         (clock),
        .reset         (reset),
        .read          (read),
        .write         (write),
        .address       (address),
        .writedata     (writedata),
        .readdata      (readdata),
        .busywait      (busywait),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata),
        .mem_busywait  (mem_busywait)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory: busywait rises with the request and falls after two counted edges.
    logic [1:0] mem_cnt;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_cnt <= 2'd0;
        end else if (mem_read || mem_write) begin
            mem_cnt <= (mem_cnt == 2'd2) ? 2'd0 : mem_cnt + 2'd1;
        end else begin
            mem_cnt <= 2'd0;
        end
    end
    assign mem_busywait = (mem_read || mem_write) && (mem_cnt != 2'd2);

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_ready(input int budget, output int cycles);
        cycles = 0;
        while (busywait && cycles < budget) begin
            tick();
            cycles++;
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        reset = 1'b1; read = 1'b0; write = 1'b0;
        address = 8'h00; writedata = 8'h00; mem_readdata = 32'h0;
        tick(); tick();

        chk("rst_busywait", {31'b0, busywait}, 0);
        chk("rst_mem_read", {31'b0, mem_read}, 0);
        chk("rst_mem_write", {31'b0, mem_write}, 0);
        chk("rst_mem_address", {26'b0, mem_address}, 0);
        chk("rst_mem_writedata", mem_writedata, 0);
        chk("rst_readdata", {24'b0, readdata}, 0);
        read = 1'b1; address = 8'h05; mem_readdata = 32'hDDCCBBAA;
        #1;
        chk("rst_busywait_req", {31'b0, busywait}, 0);

        // 1: cold read miss, fetch, hit
        reset = 1'b0;
        #1;
        chk("t1_busywait_miss", {31'b0, busywait}, 1);
        tick();
        chk("t1_mem_read", {31'b0, mem_read}, 1);
        chk("t1_mem_write", {31'b0, mem_write}, 0);
        chk("t1_mem_address", {26'b0, mem_address}, 32'h01);
        wait_ready(20, cyc);
        chk("t1_latency", 1 + cyc, 5);
        chk("t1_readdata", {24'b0, readdata}, 32'hBB);
        chk("t1_mem_idle", {30'b0, mem_read, mem_write}, 0);
        tick();
        mem_readdata = 32'h0;
        #1;
        chk("t1_rehit_busy", {31'b0, busywait}, 0);
        chk("t1_rehit_data", {24'b0, readdata}, 32'hBB);
        tick();
        chk("t1_rehit_no_memrd", {31'b0, mem_read}, 0);

        // 2: write hit then read back
        read = 1'b0; write = 1'b1; address = 8'h06; writedata = 8'h5A;
        #1;
        chk("t2_wr_busy", {31'b0, busywait}, 0);
        chk("t2_wr_mem", {30'b0, mem_read, mem_write}, 0);
        tick();
        write = 1'b0; read = 1'b1; address = 8'h06;
        #1;
        chk("t2_rd_data", {24'b0, readdata}, 32'h5A);
        chk("t2_rd_busy", {31'b0, busywait}, 0);

        // 3: conflict miss on dirty set 1 -> writeback then fetch
        tick();
        address = 8'h26; mem_readdata = 32'h44332211;
        #1;
        chk("t3_busy", {31'b0, busywait}, 1);
        tick();
        chk("t3_wb_write", {31'b0, mem_write}, 1);
        chk("t3_wb_read", {31'b0, mem_read}, 0);
        chk("t3_wb_addr", {26'b0, mem_address}, 32'h01);
        chk("t3_wb_data", mem_writedata, 32'hDD5ABBAA);
        cyc = 0;
        while (!mem_read && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("t3_fetch_read", {31'b0, mem_read}, 1);
        chk("t3_fetch_write", {31'b0, mem_write}, 0);
        chk("t3_fetch_addr", {26'b0, mem_address}, 32'h09);
        wait_ready(20, cyc);
        chk("t3_done", {31'b0, busywait}, 0);
        chk("t3_readdata", {24'b0, readdata}, 32'h33);

        // 4: write miss on clean set -> fetch only, merge on hit cycle
        tick();
        read = 1'b0;
        reset = 1'b1;
        #1;
        chk("t4_rst_readdata", {24'b0, readdata}, 0);
        tick();
        reset = 1'b0;
        write = 1'b1; address = 8'h10; writedata = 8'h77; mem_readdata = 32'hA0B0C0D0;
        #1;
        chk("t4_busy", {31'b0, busywait}, 1);
        tick();
        chk("t4_fetch_read", {31'b0, mem_read}, 1);
        chk("t4_fetch_write", {31'b0, mem_write}, 0);
        chk("t4_fetch_addr", {26'b0, mem_address}, 32'h04);
        wait_ready(20, cyc);
        chk("t4_done", {31'b0, busywait}, 0);
        chk("t4_premerge", {24'b0, readdata}, 32'hD0);
        tick();
        write = 1'b0; read = 1'b1; address = 8'h10;
        #1;
        chk("t4_rd_data", {24'b0, readdata}, 32'h77);
        chk("t4_rd_busy", {31'b0, busywait}, 0);
        tick();
        address = 8'h30;
        #1;
        chk("t4_evict_busy", {31'b0, busywait}, 1);
        tick();
        chk("t4_wb_write", {31'b0, mem_write}, 1);
        chk("t4_wb_addr", {26'b0, mem_address}, 32'h04);
        chk("t4_wb_data", mem_writedata, 32'hA0B0C077);
        read = 1'b0;
        repeat (12) tick();
        chk("t4_abandon_idle", {30'b0, mem_read, mem_write}, 0);
        read = 1'b1;
        #1;
        chk("t4_abandon_hit", {31'b0, busywait}, 0);
        chk("t4_abandon_data", {24'b0, readdata}, 32'hD0);

        // 5: reset in the middle of a fetch
        tick();
        address = 8'h05; mem_readdata = 32'h11223344;
        #1;
        chk("t5_busy", {31'b0, busywait}, 1);
        tick();
        chk("t5_fetch_read", {31'b0, mem_read}, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("t5_rst_mem_read", {31'b0, mem_read}, 0);
        chk("t5_rst_busy", {31'b0, busywait}, 0);
        chk("t5_rst_addr", {26'b0, mem_address}, 0);
        tick();
        reset = 1'b0;
        #1;
        chk("t5_rel_busy", {31'b0, busywait}, 1);
        tick();
        chk("t5_reissue_read", {31'b0, mem_read}, 1);
        chk("t5_reissue_addr", {26'b0, mem_address}, 32'h01);
        wait_ready(20, cyc);
        chk("t5_done", {31'b0, busywait}, 0);
        chk("t5_readdata", {24'b0, readdata}, 32'h33);

        // 6: read and write together is no request
        tick();
        read = 1'b1; write = 1'b1; writedata = 8'hFF;
        #1;
        chk("t6_busy", {31'b0, busywait}, 0);
        chk("t6_mem", {30'b0, mem_read, mem_write}, 0);
        tick();
        chk("t6_mem_after", {30'b0, mem_read, mem_write}, 0);
        write = 1'b0;
        #1;
        chk("t6_unchanged", {24'b0, readdata}, 32'h33);
        chk("t6_still_hit", {31'b0, busywait}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
